// File: rtl/mdu_e_pkg.sv
// Shared MDU constants: op codes seen by both the controller and the E-stage
// multiply/divide unit, plus the unit's FSM encoding.
package mdu_e_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: multi-cycle mult/div with a pending result
// that commits into HI/LO only when the busy countdown expires.
module mdu_e
  import mdu_e_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = max_int(MULT_CYCLES, DIV_CYCLES);
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [63:0]      r_pend, w_pend_nxt;
  logic [31:0]      r_hi, w_hi_nxt;
  logic [31:0]      r_lo, w_lo_nxt;

  mdu_op_e     w_op;
  logic        w_signed;
  logic [63:0] w_prod;
  logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quot, w_rem;
  logic [63:0] w_result;

  assign w_op = mdu_op_e'(op);

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly
  // instead of relying on a signed-overflow corner of the divider.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    w_prod   = w_signed ? ({{32{A[31]}}, A} * {{32{B[31]}}, B})
                        : ({32'd0, A} * {32'd0, B});
    w_a_mag  = (w_signed && A[31]) ? -A : A;
    w_b_mag  = (w_signed && B[31]) ? -B : B;
    w_q_mag  = w_a_mag / w_b_mag;
    w_r_mag  = w_a_mag % w_b_mag;
    w_quot   = (w_signed && (A[31] ^ B[31])) ? -w_q_mag : w_q_mag;
    w_rem    = (w_signed && A[31]) ? -w_r_mag : w_r_mag;
    if (w_op == OP_MULT || w_op == OP_MULTU) begin
      w_result = w_prod;
    end else if (B == 32'd0) begin
      w_result = {A, 32'hFFFF_FFFF};
    end else begin
      w_result = {w_rem, w_quot};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (w_op)
            OP_MULT, OP_MULTU: begin
              w_pend_nxt  = w_result;
              w_cnt_nxt   = MULT_LOAD;
              w_state_nxt = ST_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              w_pend_nxt  = w_result;
              w_cnt_nxt   = DIV_LOAD;
              w_state_nxt = ST_BUSY;
            end
            OP_MTHI: w_hi_nxt = A;
            OP_MTLO: w_lo_nxt = A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        // start is deliberately not looked at here: anything issued while busy is dropped.
        if (r_cnt == '0) begin
          w_hi_nxt    = r_pend[63:32];
          w_lo_nxt    = r_pend[31:0];
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  assign busy = (r_state == ST_BUSY);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: directed corner cases plus randomized ops
// compared against a 64-bit arithmetic model of HI/LO and busy timing.
module tb_mdu_e;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] f_op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (f_op)
      3'd0: res = sa * sb;
      3'd1: res = ua * ub;
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (f_op == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Issue a mult/div at the current negedge; optionally inject another start at busy cycle intr_at.
  task automatic run_long(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b,
                          input int intr_at, input logic [2:0] intr_op,
                          input logic [31:0] intr_a, input string tag);
    int n;
    logic [63:0] res;
    n   = (f_op < 3'd2) ? MC : DC;
    res = ref_result(f_op, a, b);
    start = 1'b1; op = f_op; A = a; B = b;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, ":busy"}, {63'd0, busy}, 64'd1);
      check({tag, ":hold"}, {hi, lo}, {m_hi, m_lo});
      if (i == intr_at) begin
        start = 1'b1; op = intr_op; A = intr_a; B = $urandom;
      end
    end
    @(negedge clk);
    start = 1'b0;
    {m_hi, m_lo} = res;
    check({tag, ":done"}, {63'd0, busy}, 64'd0);
    check({tag, ":hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  // Single-edge ops: mthi, mtlo and the no-op codes.
  task automatic run_short(input logic [2:0] f_op, input logic [31:0] a, input string tag);
    start = 1'b1; op = f_op; A = a; B = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (f_op == 3'd4) m_hi = a;
    if (f_op == 3'd5) m_lo = a;
    check({tag, ":busy"}, {63'd0, busy}, 64'd0);
    check({tag, ":hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 reset = 1'b0;
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Start on the very first edge after release, then the directed corners.
    run_long(3'd0, 32'hFFFF_FFFD, 32'd5, 0, 3'd0, 32'd0, "mult_neg");
    run_long(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, 32'd0, "multu_max");
    run_long(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 32'd0, "div_neg");
    run_long(3'd3, 32'd7, 32'd0, 0, 3'd0, 32'd0, "divu_zero");
    run_long(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 32'd0, "div_ovf");
    run_long(3'd2, 32'hFFFF_FF00, 32'd0, 0, 3'd0, 32'd0, "div_zero");
    run_long(3'd2, 32'd7, 32'hFFFF_FFFE, 0, 3'd0, 32'd0, "div_negdvr");
    run_long(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 2, 3'd4, 32'h1234, "mult_intr");
    run_short(3'd4, 32'h0000_1234, "mthi_b2b");
    run_short(3'd5, 32'hCAFE_F00D, "mtlo");
    run_short(3'd6, 32'hDEAD_BEEF, "nop6");
    run_short(3'd7, 32'hDEAD_BEEF, "nop7");
    run_long(3'd3, 32'hFFFF_FFFF, 32'd3, DC, 3'd3, 32'd5, "divu_intr_last");

    // Reset in the middle of a divide: outputs clear at once and nothing commits later.
    start = 1'b1; op = 3'd2; A = 32'h0000_0064; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    reset = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < DC + 2; i++) begin
      @(negedge clk);
      check("rst_nocommit_busy", {63'd0, busy}, 64'd0);
      check("rst_nocommit_hilo", {hi, lo}, 64'd0);
    end
    reset = 1'b0;
    #2 reset = 1'b1;
    run_long(3'd2, 32'hFFFF_FF9C, 32'd7, 0, 3'd0, 32'd0, "div_after_rst");

    // Randomized mix, including starts injected while busy.
    for (int k = 0; k < 60; k++) begin
      logic [2:0] r_op;
      int lim;
      r_op = 3'($urandom_range(0, 7));
      if (r_op < 3'd4) begin
        lim = (r_op < 3'd2) ? MC : DC;
        run_long(r_op, pick_operand(), pick_operand(), $urandom_range(0, lim),
                 3'($urandom_range(0, 7)), $urandom, "rand_long");
      end else begin
        run_short(r_op, $urandom, "rand_short");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_e.md
MDU_E -- requirements
Module: mdu_e

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 SHALL have port op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op.
REQ-007 SHALL have port A  input  32  forwarded rs value, E stage.
REQ-008 SHALL have port B  input  32  forwarded rt value, E stage.
REQ-009 SHALL have port busy  output  1  operation in flight; hazard unit stalls MDU instructions in D.
REQ-010 SHALL have port hi  output  32  architectural HI register, read by mfhi.
REQ-011 SHALL have port lo  output  32  architectural LO register, read by mflo.

Function
REQ-012 SHALL implement two states: IDLE and BUSY, plus a down-counter cnt sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 In IDLE, with start=1 and op in 0-3, SHALL compute the result from A/B at that edge, latch it into pending registers, load cnt with N-1, and enter BUSY.
REQ-014 SHALL assert busy for exactly N cycles after the start edge, where N is MULT_CYCLES or DIV_CYCLES.
REQ-015 SHALL decrement cnt each BUSY cycle; at the edge where cnt=0, SHALL copy pending to hi/lo and return to IDLE in the same edge, with busy=0 after that edge.
REQ-016 hi/lo SHALL keep their old values throughout BUSY; new values SHALL be visible only after the commit edge.
REQ-017 mult/multu SHALL form a 64-bit signed/unsigned product {hi,lo}.
REQ-018 div/divu SHALL set lo=quotient and hi=remainder, with signed quotient truncated toward zero and remainder sign equal to dividend sign.
REQ-019 For signed 0x80000000 / 0xFFFFFFFF, SHALL set lo=0x80000000 and hi=0.
REQ-020 For divisor 0 (div or divu), SHALL set hi=A and lo=0xFFFFFFFF.
REQ-021 In IDLE, with start=1, op=4 or op=5, SHALL write A into hi or lo at that edge; busy SHALL stay 0.
REQ-022 SHALL ignore start while BUSY, for every op, leaving state, cnt, pending, hi and lo unaffected.
REQ-023 SHALL treat op 6-7 with start=1 as a no-op.
REQ-024 Back-to-back operation: start in the first IDLE cycle after a commit SHALL be accepted.

Reset
REQ-025 reset=0 SHALL immediately, independent of clk, force state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending=0.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight result, with no later commit.
REQ-027 The first edge after reset release SHALL accept a start.

Structure
REQ-028 MDU op codes 0-7 SHALL reside in the shared pipeline constants header/package, which the controller also includes.
REQ-029 The block SHALL be a single module with no sub-modules; result computation SHALL be a combinational block inside it.

Verification
REQ-030 mult A=0xFFFFFFFD, B=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-031 multu A=0xFFFFFFFF, B=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; during busy, hi/lo hold prior values.
REQ-032 div A=0xFFFFFFF9, B=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 divu A=7, B=0 -> after 10 cycles hi=7, lo=0xFFFFFFFF.
REQ-034 mult in flight, then mthi A=0x1234 at cycle 2 -> ignored; commit occurs at cycle 5 with the product; mthi issued after commit -> hi=0x00001234 next edge, busy stays 0.
REQ-035 Start div, assert reset at cycle 4 -> busy, hi and lo go 0 immediately; no commit follows; start at first edge after release is accepted.
